aes_block_serializer: RTL and testbench

Output-side stream adapter for the AES HWPE datapath. It accepts 128-bit ciphertext blocks from the AES engine core over a valid/ready block handshake. It emits each block as four 32-bit words on an HWPE-style valid/ready output stream, most-significant word first. A two-entry block buffer lets the core hand over the next block while the current one is still draining, so a continuously ready sink sees one word per cycle.

---
 rtl/aes_block_serializer.sv | 110 +++++++++++
 tb/tb_aes_block_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_serializer.sv
// Serializes 128-bit AES ciphertext blocks into a most-significant-word-first
// 32-bit valid/ready stream, using a two-entry block FIFO to hide handover gaps.
module aes_block_serializer #(
    parameter int BLOCK_WIDTH = 128,
    parameter int WORD_WIDTH  = 32,
    parameter int NUM_WORDS   = BLOCK_WIDTH / WORD_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [BLOCK_WIDTH-1:0] blk_data_i,
    output logic                   word_valid_o,
    input  logic                   word_ready_i,
    output logic [WORD_WIDTH-1:0]  word_data_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic [15:0]            blocks_done_o
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

    logic [BLOCK_WIDTH-1:0] r_buf [0:1];
    logic                   r_head;
    logic                   r_tail;
    logic [1:0]             r_count;
    logic [IDX_W-1:0]       r_idx;
    logic [15:0]            r_blocks_done;

    logic                   w_blk_ready;
    logic                   w_word_valid;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic                   w_idx_last;
    logic                   w_out_last_hs;
    logic [BLOCK_WIDTH-1:0] w_head_blk;
    logic [WORD_WIDTH-1:0]  w_words [0:NUM_WORDS-1];

    // clear_i gates both sides so no transfer can coincide with a flush
    assign w_blk_ready   = (r_count < 2'd2) & ~clear_i;
    assign w_word_valid  = (r_count != 2'd0) & ~clear_i;
    assign w_in_hs       = blk_valid_i & w_blk_ready;
    assign w_out_hs      = w_word_valid & word_ready_i;
    assign w_idx_last    = (r_idx == IDX_LAST);
    assign w_out_last_hs = w_out_hs & w_idx_last;
    assign w_head_blk    = r_buf[r_head];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word_slice
            assign w_words[gi] = w_head_blk[BLOCK_WIDTH-1-gi*WORD_WIDTH -: WORD_WIDTH];
        end

        for (gi = 0; gi < 2; gi++) begin : g_buf_entry
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_buf[gi] <= '0;
                end else if (w_in_hs && (r_tail == 1'(gi))) begin
                    r_buf[gi] <= blk_data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
            r_count       <= 2'd0;
            r_idx         <= '0;
            r_blocks_done <= 16'd0;
        end else if (clear_i) begin
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
            r_count       <= 2'd0;
            r_idx         <= '0;
            r_blocks_done <= 16'd0;
        end else begin
            if (w_in_hs) begin
                r_tail <= ~r_tail;
            end
            if (w_out_hs) begin
                if (w_idx_last) begin
                    r_idx         <= '0;
                    r_head        <= ~r_head;
                    r_blocks_done <= r_blocks_done + 16'd1;
                end else begin
                    r_idx <= r_idx + IDX_ONE;
                end
            end
            // a simultaneous accept and final-word retire leaves occupancy unchanged
            case ({w_in_hs, w_out_last_hs})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign blk_ready_o   = w_blk_ready;
    assign word_valid_o  = w_word_valid;
    assign word_data_o   = w_words[r_idx];
    assign last_o        = w_word_valid & w_idx_last;
    assign busy_o        = (r_count != 2'd0);
    assign blocks_done_o = r_blocks_done;

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed bench for aes_block_serializer: single block, backpressure,
// streaming, full buffer, clear and asynchronous reset mid-block.
module tb_aes_block_serializer;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         clear_i;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [127:0] blk_data_i;
    logic         word_valid_o;
    logic         word_ready_i;
    logic [31:0]  word_data_o;
    logic         last_o;
    logic         busy_o;
    logic [15:0]  blocks_done_o;

    int checks = 0;
    int errors = 0;

    logic [127:0] blks [0:3];
    logic [127:0] key_blk;

    aes_block_serializer dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .blk_valid_i   (blk_valid_i),
        .blk_ready_o   (blk_ready_o),
        .blk_data_i    (blk_data_i),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .word_data_o   (word_data_o),
        .last_o        (last_o),
        .busy_o        (busy_o),
        .blocks_done_o (blocks_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [127:0] b, input int i);
        return b[127-32*i -: 32];
    endfunction

    task automatic expect_word(input string tag, input logic [31:0] w, input logic l);
        chk({tag, "_valid"}, {31'd0, word_valid_o}, 32'd1);
        chk({tag, "_data"}, word_data_o, w);
        chk({tag, "_last"}, {31'd0, last_o}, {31'd0, l});
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    initial begin
        int src;
        blks[0] = 128'h7649abac8119b246cee98e9b12e9197d;
        blks[1] = 128'h5086cb9b507219ee95db113a917678b2;
        blks[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
        blks[3] = 128'h3ff1caa1681fac09120eca307586e1a7;
        key_blk = 128'h2b7e151628aed2a6abf7158809cf4f3c;

        rst_i = 1'b1; clear_i = 1'b0; blk_valid_i = 1'b0;
        blk_data_i = '0; word_ready_i = 1'b0;
        #2;
        chk("rst_valid", {31'd0, word_valid_o}, 32'd0);
        chk("rst_last", {31'd0, last_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_data", word_data_o, 32'h0);
        chk("rst_done", {16'd0, blocks_done_o}, 32'd0);
        chk("rst_ready", {31'd0, blk_ready_o}, 32'd1);
        cyc(); rst_i = 1'b0;

        // single block, sink always ready
        cyc(); blk_valid_i = 1'b1; blk_data_i = blks[0]; word_ready_i = 1'b1;
        #1 chk("single_ready", {31'd0, blk_ready_o}, 32'd1);
        chk("single_idle_valid", {31'd0, word_valid_o}, 32'd0);
        cyc(); blk_valid_i = 1'b0;
        #1 expect_word("single_w0", 32'h7649abac, 1'b0);
        cyc(); #1 expect_word("single_w1", 32'h8119b246, 1'b0);
        cyc(); #1 expect_word("single_w2", 32'hcee98e9b, 1'b0);
        cyc(); #1 expect_word("single_w3", 32'h12e9197d, 1'b1);
        chk("single_done_pre", {16'd0, blocks_done_o}, 32'd0);
        cyc(); #1 chk("single_valid_after", {31'd0, word_valid_o}, 32'd0);
        chk("single_busy_after", {31'd0, busy_o}, 32'd0);
        chk("single_done", {16'd0, blocks_done_o}, 32'd1);

        // backpressure after the second word
        cyc(); blk_valid_i = 1'b1; blk_data_i = blks[0];
        cyc(); blk_valid_i = 1'b0;
        #1 expect_word("bp_w0", 32'h7649abac, 1'b0);
        cyc(); #1 expect_word("bp_w1", 32'h8119b246, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(); word_ready_i = 1'b0;
            #1 expect_word("bp_hold", 32'hcee98e9b, 1'b0);
        end
        cyc(); word_ready_i = 1'b1;
        #1 expect_word("bp_w2", 32'hcee98e9b, 1'b0);
        cyc(); #1 expect_word("bp_w3", 32'h12e9197d, 1'b1);
        cyc(); #1 chk("bp_valid_after", {31'd0, word_valid_o}, 32'd0);
        chk("bp_done", {16'd0, blocks_done_o}, 32'd2);

        // clear while idle, then stream four blocks back to back
        cyc(); clear_i = 1'b1;
        #1 chk("clr_idle_ready", {31'd0, blk_ready_o}, 32'd0);
        cyc(); clear_i = 1'b0;
        #1 chk("clr_idle_done", {16'd0, blocks_done_o}, 32'd0);
        src = 0;
        blk_valid_i = 1'b1; blk_data_i = blks[0];
        #1 if (blk_ready_o) src++;
        for (int k = 0; k < 16; k++) begin
            cyc();
            blk_valid_i = (src < 4);
            blk_data_i  = blks[(src < 4) ? src : 3];
            #1 expect_word("stream", wd(blks[k/4], k%4), (k%4) == 3);
            if (blk_valid_i && blk_ready_o) src++;
        end
        cyc(); blk_valid_i = 1'b0;
        #1 chk("stream_src", src, 32'd4);
        chk("stream_valid_after", {31'd0, word_valid_o}, 32'd0);
        chk("stream_done", {16'd0, blocks_done_o}, 32'd4);

        // full buffer: third block must wait for the first block's last word
        cyc(); word_ready_i = 1'b0; blk_valid_i = 1'b1; blk_data_i = blks[0];
        #1 chk("full_ready0", {31'd0, blk_ready_o}, 32'd1);
        cyc(); blk_data_i = blks[1];
        #1 chk("full_ready1", {31'd0, blk_ready_o}, 32'd1);
        cyc(); blk_data_i = blks[2];
        #1 chk("full_ready2", {31'd0, blk_ready_o}, 32'd0);
        chk("full_busy", {31'd0, busy_o}, 32'd1);
        cyc(); #1 chk("full_ready_hold", {31'd0, blk_ready_o}, 32'd0);
        expect_word("full_stall_w0", 32'h7649abac, 1'b0);
        src = 2;
        for (int k = 0; k < 12; k++) begin
            cyc();
            word_ready_i = 1'b1;
            blk_valid_i  = (src < 3);
            blk_data_i   = blks[(src < 3) ? src : 2];
            #1 expect_word("full", wd(blks[k/4], k%4), (k%4) == 3);
            if (k == 3) chk("full_ready_at_last", {31'd0, blk_ready_o}, 32'd0);
            if (k == 4) chk("full_ready_after_last", {31'd0, blk_ready_o}, 32'd1);
            if (blk_valid_i && blk_ready_o) src++;
        end
        cyc(); blk_valid_i = 1'b0;
        #1 chk("full_src", src, 32'd3);
        chk("full_done", {16'd0, blocks_done_o}, 32'd7);

        // clear after two words of a block
        cyc(); blk_valid_i = 1'b1; blk_data_i = blks[1];
        cyc(); blk_valid_i = 1'b0;
        #1 expect_word("clr_w0", 32'h5086cb9b, 1'b0);
        cyc(); #1 expect_word("clr_w1", 32'h507219ee, 1'b0);
        cyc(); clear_i = 1'b1;
        #1 chk("clr_valid", {31'd0, word_valid_o}, 32'd0);
        chk("clr_ready", {31'd0, blk_ready_o}, 32'd0);
        chk("clr_last", {31'd0, last_o}, 32'd0);
        cyc(); clear_i = 1'b0;
        #1 chk("clr_busy", {31'd0, busy_o}, 32'd0);
        chk("clr_valid_after", {31'd0, word_valid_o}, 32'd0);
        chk("clr_done", {16'd0, blocks_done_o}, 32'd0);
        cyc(); blk_valid_i = 1'b1; blk_data_i = blks[3];
        cyc(); blk_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 expect_word("clr_next", wd(blks[3], k), k == 3);
            cyc();
        end
        #1 chk("clr_next_done", {16'd0, blocks_done_o}, 32'd1);

        // asynchronous reset between edges, mid-block
        blk_valid_i = 1'b1; blk_data_i = blks[2];
        cyc(); blk_valid_i = 1'b0;
        #1 expect_word("rstmid_w0", 32'h73bed6b8, 1'b0);
        cyc(); #1 expect_word("rstmid_w1", 32'he3c1743b, 1'b0);
        #1 rst_i = 1'b1;
        #1 chk("rstmid_valid", {31'd0, word_valid_o}, 32'd0);
        chk("rstmid_last", {31'd0, last_o}, 32'd0);
        chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
        chk("rstmid_data", word_data_o, 32'h0);
        chk("rstmid_done", {16'd0, blocks_done_o}, 32'd0);
        chk("rstmid_ready", {31'd0, blk_ready_o}, 32'd1);
        cyc(); rst_i = 1'b0;
        cyc(); blk_valid_i = 1'b1; blk_data_i = key_blk;
        cyc(); blk_valid_i = 1'b0;
        #1 expect_word("post_w0", 32'h2b7e1516, 1'b0);
        cyc(); #1 expect_word("post_w1", 32'h28aed2a6, 1'b0);
        cyc(); #1 expect_word("post_w2", 32'habf71588, 1'b0);
        cyc(); #1 expect_word("post_w3", 32'h09cf4f3c, 1'b1);
        cyc(); #1 chk("post_done", {16'd0, blocks_done_o}, 32'd1);
        chk("post_busy", {31'd0, busy_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
